// File: rtl/equiv_sweep_ctrl.sv
// Exhaustive two-input sweep sequencer for gate-identity checking, with a latched pass/fail report.
// Optional feature: define EQ_STOP_ON_FAIL_EN to end a sweep at the first mismatching vector.
module equiv_sweep_ctrl #(
    parameter int unsigned NUM_PAIRS = 3,
    parameter int unsigned SETTLE    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [NUM_PAIRS-1:0] f_lhs_i,
    input  logic [NUM_PAIRS-1:0] f_rhs_i,
    output logic                 a_o,
    output logic                 b_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [NUM_PAIRS-1:0] mismatch_o,
    output logic [2:0]           first_fail_pair_o,
    output logic [1:0]           first_fail_vec_o
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned VEC_W = 2;

`ifdef EQ_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [NUM_PAIRS-1:0] mism_q, mism_d;
    logic [2:0]           ffp_q, ffp_d;
    logic [1:0]           ffv_q, ffv_d;

    logic [NUM_PAIRS-1:0] diff;
    logic [2:0]           low_idx;

    // Lowest failing pair index of the current compare.
    always_comb begin
        diff    = f_lhs_i ^ f_rhs_i;
        low_idx = '0;
        for (int i = int'(NUM_PAIRS) - 1; i >= 0; i--) begin
            if (diff[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        mism_d  = mism_q;
        ffp_d   = ffp_q;
        ffv_d   = ffv_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_SETTLE;
                    cnt_d   = CNT_W'(SETTLE);
                    vec_d   = '0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    mism_d  = '0;
                    ffp_d   = '0;
                    ffv_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CHECK: begin
                mism_d = mism_q | diff;
                // An all-zero mask means no earlier vector has failed in this sweep.
                if (diff != '0 && mism_q == '0) begin
                    ffp_d = low_idx;
                    ffv_d = vec_q;
                end
                if (vec_q == VEC_W'(3) || (STOP_ON_FAIL && diff != '0)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (mism_d == '0);
                end else begin
                    state_d = S_SETTLE;
                    vec_d   = vec_q + VEC_W'(1);
                    cnt_d   = CNT_W'(SETTLE);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mism_q  <= '0;
            ffp_q   <= '0;
            ffv_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mism_q  <= mism_d;
            ffp_q   <= ffp_d;
            ffv_q   <= ffv_d;
        end
    end

    assign a_o               = vec_q[1];
    assign b_o               = vec_q[0];
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pass_o            = pass_q;
    assign mismatch_o        = mism_q;
    assign first_fail_pair_o = ffp_q;
    assign first_fail_vec_o  = ffv_q;

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Scoreboard bench for equiv_sweep_ctrl: gate-identity networks with injectable faults, checked against a sweep model.
module tb_equiv_sweep_ctrl;

    localparam int unsigned S  = 1;
    localparam int unsigned S4 = 4;

    typedef struct packed {
        logic        pass;
        logic [2:0]  mism;
        logic [2:0]  ffp;
        logic [1:0]  ffv;
        int unsigned len;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start, start4;

    logic       a, b, busy, done, pass;
    logic [2:0] lhs, rhs, rhs_ok, mism, ffp;
    logic [1:0] ffv;
    logic [2:0] ft_tab [4];

    logic       a4, b4, busy4, done4, pass4;
    logic [2:0] lhs4, rhs4, mism4, ffp4;
    logic [1:0] ffv4;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    int unsigned busy_cnt = 0;

    always #5 clk = ~clk;

    equiv_sweep_ctrl #(.NUM_PAIRS(3), .SETTLE(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .f_lhs_i(lhs), .f_rhs_i(rhs),
        .a_o(a), .b_o(b), .busy_o(busy), .done_o(done), .pass_o(pass),
        .mismatch_o(mism), .first_fail_pair_o(ffp), .first_fail_vec_o(ffv)
    );

    equiv_sweep_ctrl #(.NUM_PAIRS(3), .SETTLE(S4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start4), .f_lhs_i(lhs4), .f_rhs_i(rhs4),
        .a_o(a4), .b_o(b4), .busy_o(busy4), .done_o(done4), .pass_o(pass4),
        .mismatch_o(mism4), .first_fail_pair_o(ffp4), .first_fail_vec_o(ffv4)
    );

    // NAND vs negative-OR, NOR vs negative-AND, XOR vs OR-and-not-AND; faults flip rhs bits per vector.
    always_comb begin
        lhs[0]    = ~(a & b);
        rhs_ok[0] = ~a | ~b;
        lhs[1]    = ~(a | b);
        rhs_ok[1] = ~a & ~b;
        lhs[2]    = a ^ b;
        rhs_ok[2] = (a | b) & ~(a & b);
        rhs       = rhs_ok ^ ft_tab[{a, b}];
        lhs4      = {a4 ^ b4, ~(a4 | b4), ~(a4 & b4)};
        rhs4      = {(a4 | b4) & ~(a4 & b4), ~a4 & ~b4, ~a4 | ~b4};
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0][2:0] ft);
        exp_t e;
        bit   found = 1'b0;
        e = '0;
        e.len = 4 * (S + 1);
        for (int v = 0; v < 4; v++) begin
            if (ft[v] != 3'b000 && !found) begin
                found = 1'b1;
                e.ffv = 2'(v);
                for (int i = 2; i >= 0; i--) begin
                    if (ft[v][i]) e.ffp = 3'(i);
                end
            end
            e.mism = e.mism | ft[v];
`ifdef EQ_STOP_ON_FAIL_EN
            if (ft[v] != 3'b000) begin
                e.len = (v + 1) * (S + 1);
                break;
            end
`endif
        end
        e.pass = (e.mism == 3'b000);
        return e;
    endfunction

    // Monitor: operand sequence while busy, and scoreboard pop on every done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) begin
                int unsigned k;
                busy_cnt++;
                k = (busy_cnt - 1) / (S + 1);
                if (k > 3) k = 3;
                chk("ab_vector", int'({a, b}), int'(k));
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pass", int'(pass), int'(e.pass));
                    chk("mismatch", int'(mism), int'(e.mism));
                    chk("first_fail_pair", int'(ffp), int'(e.ffp));
                    chk("first_fail_vec", int'(ffv), int'(e.ffv));
                    chk("busy_len", int'(busy_cnt), int'(e.len));
                    chk("busy_low_in_done", int'(busy), 0);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic run_sweep(input logic [3:0][2:0] ft, input logic [31:0] extra);
        exp_t e;
        bit   seen = 1'b0;
        for (int v = 0; v < 4; v++) ft_tab[v] = ft[v];
        e = model(ft);
        q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        for (int c = 1; c < 200 && !seen; c++) begin
            start = extra[c];
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        chk("held_pass", int'(pass), int'(e.pass));
        chk("held_mismatch", int'(mism), int'(e.mism));
        chk("idle_busy", int'(busy), 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ab", int'({a, b}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_mismatch", int'(mism), 0);
        chk("rst_ffp", int'(ffp), 0);
        chk("rst_ffv", int'(ffv), 0);
    endtask

    initial begin
        logic [3:0][2:0] ft;
        logic [31:0]     mask;
        exp_t            e;
        int              c;
        int              bc;

        rst_n  = 1'b0;
        start  = 1'b0;
        start4 = 1'b0;
        for (int v = 0; v < 4; v++) ft_tab[v] = 3'b000;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        ft = '0;
        run_sweep(ft, 32'h0);
        ft = '0; ft[2] = 3'b010;
        run_sweep(ft, 32'h0);
        ft = '0; ft[1] = 3'b101; ft[3] = 3'b100;
        run_sweep(ft, 32'h0);
        ft = '0; ft[2] = 3'b010;
        run_sweep(ft, (32'h1 << 3) | (32'h1 << 8));

        // Abort a failing sweep with reset, then a clean sweep.
        ft = '0; ft[0] = 3'b001;
        for (int v = 0; v < 4; v++) ft_tab[v] = ft[v];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ft = '0;
        run_sweep(ft, 32'h0);

        // Longer settle on the second instance.
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        c  = 0;
        bc = 0;
        while (!done4 && c < 100) begin
            if (busy4) bc++;
            @(negedge clk);
            c++;
        end
        chk("s4_done_edge", c, 4 * (S4 + 1));
        chk("s4_busy_cycles", bc, 4 * (S4 + 1));
        chk("s4_pass", int'(pass4), 1);
        chk("s4_mismatch", int'(mism4), 0);
        repeat (2) @(negedge clk);

        for (int n = 0; n < 24; n++) begin
            for (int v = 0; v < 4; v++) begin
                ft[v] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            end
            e    = model(ft);
            mask = (32'h1 << e.len) - 32'h2;
            run_sweep(ft, $urandom & mask);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
